// File: rtl/adjust_bitwidth_pkg.sv
// adjust_bitwidth_pkg: shared types and helpers for the streaming complex bitwidth adjuster
package adjust_bitwidth_pkg;
  typedef logic signed [31:0] part_t;
  typedef struct packed { part_t im; part_t re; } cplx_t;
  typedef struct packed { logic ovf; part_t val; } clip_t;
  function automatic int max_sel(input int iw, input int ow);
    return iw > ow ? iw - ow : 0;
  endfunction
  function automatic clip_t clip(input part_t v, input int ow);
    part_t hi, lo;
    clip_t r;
    hi = (part_t'(1) <<< (ow - 1)) - part_t'(1);
    lo = -hi - part_t'(1);
    r.ovf = (v > hi) || (v < lo);
    r.val = v > hi ? hi : v < lo ? lo : v;
    return r;
  endfunction
endpackage

// File: rtl/adjust_bitwidth_stream_cplx_part_scale.sv
// cplx_part_scale: per-part round/shift (stage 1) and clip/wrap (stage 2) datapath.
// Rounding is enabled by defining ADJUST_BITWIDTH_STREAM_ROUND_EN.
module cplx_part_scale
  import adjust_bitwidth_pkg::*;
#(
  parameter int IW     = 10,
  parameter int OW     = 8,
  parameter int SEL_W  = 4,
  parameter int SAT_EN = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [SEL_W-1:0]     sel_i,
  input  logic signed [IW-1:0] x_i,
  output logic signed [OW-1:0] y_o,
  output logic                 ovf_o
);
  logic signed [IW:0] ext, rnd, s1_d, s1_q;
  logic signed [OW-1:0] y_d, y_q;
  part_t s1x;
  clip_t c;
  logic unused_hi;
  always_comb begin
    ext = {x_i[IW-1], x_i};
`ifdef ADJUST_BITWIDTH_STREAM_ROUND_EN
    rnd = (sel_i == '0) ? '0 : (IW+1)'(33'd1 << (sel_i - 1'b1));
`else
    rnd = '0;
`endif
    s1_d = en_i ? (ext + rnd) >>> sel_i : s1_q;
    s1x = part_t'(s1_q);
    c = clip(s1x, OW);
    ovf_o = c.ovf;
    // wrap keeps the sign of the shifted value and its low OW-1 bits
    y_d = en_i ? ((SAT_EN != 0) ? OW'(c.val) : {s1x[31], s1x[OW-2:0]}) : y_q;
    unused_hi = ^c.val[31:OW];
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      s1_q <= '0;
      y_q  <= '0;
    end else begin
      s1_q <= s1_d;
      y_q  <= y_d;
    end
  assign y_o = y_q;
endmodule

// File: rtl/adjust_bitwidth_stream.sv
// adjust_bitwidth_stream: 2-stage streaming complex shift/narrow with saturation reporting.
// Optional round-half-up via ADJUST_BITWIDTH_STREAM_ROUND_EN.
module adjust_bitwidth_stream
  import adjust_bitwidth_pkg::*;
#(
  parameter int IW     = 10,
  parameter int OW     = 8,
  parameter int SEL_W  = 4,
  parameter int SAT_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [2*IW-1:0]   data_i,
  input  logic              valid_i,
  input  logic              sop_i,
  input  logic              eop_i,
  output logic              ready_o,
  output logic [2*OW-1:0]   data_o,
  output logic              valid_o,
  output logic              sop_o,
  output logic              eop_o,
  input  logic              ready_i,
  output logic              sat_o,
  output logic              frame_sat_o,
  output logic [CNT_W-1:0]  sat_cnt_o,
  input  logic              clr_i
);
  localparam int MAXS = max_sel(IW, OW);
  logic en, acc, xfer, ovf_re, ovf_im;
  logic [SEL_W-1:0] sel_d, sel_q;
  logic v1_d, v1_q, sop1_d, sop1_q, eop1_d, eop1_q;
  logic valid_d, valid_q, sop_d, sop_q, eop_d, eop_q, sat_d, sat_q, sticky_d, sticky_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic signed [OW-1:0] y_re, y_im;
  always_comb begin
    en = !valid_q | ready_i;
    acc = valid_i & en;
    xfer = valid_q & ready_i;
    // the sop beat itself already uses the freshly latched shift
    sel_d = (acc & sop_i) ? ((int'(sel_i) > MAXS) ? SEL_W'(MAXS) : sel_i) : sel_q;
    v1_d = en ? valid_i : v1_q;
    sop1_d = en ? valid_i & sop_i : sop1_q;
    eop1_d = en ? valid_i & eop_i : eop1_q;
    valid_d = en ? v1_q : valid_q;
    sop_d = en ? sop1_q : sop_q;
    eop_d = en ? eop1_q : eop_q;
    sat_d = en ? v1_q & (ovf_re | ovf_im) : sat_q;
    sticky_d = xfer ? !eop_q & (sticky_q | sat_q) : sticky_q;
    cnt_d = clr_i ? '0 : (xfer & sat_q & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      sel_q    <= '0;
      v1_q     <= 1'b0;
      sop1_q   <= 1'b0;
      eop1_q   <= 1'b0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      sat_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sel_q    <= sel_d;
      v1_q     <= v1_d;
      sop1_q   <= sop1_d;
      eop1_q   <= eop1_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      sat_q    <= sat_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  cplx_part_scale #(.IW(IW), .OW(OW), .SEL_W(SEL_W), .SAT_EN(SAT_EN)) u_re (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en), .sel_i(sel_d),
    .x_i(data_i[IW-1:0]), .y_o(y_re), .ovf_o(ovf_re)
  );
  cplx_part_scale #(.IW(IW), .OW(OW), .SEL_W(SEL_W), .SAT_EN(SAT_EN)) u_im (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en), .sel_i(sel_d),
    .x_i(data_i[2*IW-1:IW]), .y_o(y_im), .ovf_o(ovf_im)
  );
  assign ready_o = en;
  assign data_o = {y_im, y_re};
  assign valid_o = valid_q;
  assign sop_o = sop_q;
  assign eop_o = eop_q;
  assign sat_o = sat_q;
  assign frame_sat_o = valid_q & eop_q & (sticky_q | sat_q);
  assign sat_cnt_o = cnt_q;
endmodule

// File: tb/tb_adjust_bitwidth_stream.sv
// tb_adjust_bitwidth_stream: directed vector table plus multi-cycle frame sequences.
module tb_adjust_bitwidth_stream;
  localparam int IW = 10, OW = 8, SEL_W = 4, CNT_W = 4;
`ifdef ADJUST_BITWIDTH_STREAM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic [SEL_W-1:0] sel_i;
  logic [2*IW-1:0] data_i;
  logic valid_i, sop_i, eop_i, ready_o, valid_o, sop_o, eop_o, ready_i;
  logic sat_o, frame_sat_o, clr_i;
  logic [2*OW-1:0] data_o;
  logic [CNT_W-1:0] sat_cnt_o;

  adjust_bitwidth_stream #(.IW(IW), .OW(OW), .SEL_W(SEL_W), .SAT_EN(1), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sel_i(sel_i), .data_i(data_i), .valid_i(valid_i),
    .sop_i(sop_i), .eop_i(eop_i), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
    .sop_o(sop_o), .eop_o(eop_o), .ready_i(ready_i), .sat_o(sat_o),
    .frame_sat_o(frame_sat_o), .sat_cnt_o(sat_cnt_o), .clr_i(clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int sel, re, im, fre, fim, fsat, rre, rim, rsat; } vec_t;
  vec_t tv[9];
  int n_chk = 0, n_err = 0;
  int in_re[32], in_im[32], o_re[32], o_im[32];
  logic o_sop[32], o_eop[32], o_sat[32], o_fs[32];
  int n_out;
  logic [SEL_W-1:0] sop_sel, oth_sel;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int ore();
    return int'($signed(data_o[OW-1:0]));
  endfunction
  function automatic int oim();
    return int'($signed(data_o[2*OW-1:OW]));
  endfunction

  task automatic run_frame(input int n, input int st_lo, input int st_hi, input bit with_sop);
    int idx;
    logic [2*OW-1:0] held;
    idx = 0;
    held = '0;
    n_out = 0;
    for (int c = 0; c < 200 && n_out < n; c++) begin
      ready_i = !(c >= st_lo && c <= st_hi);
      valid_i = idx < n;
      sop_i = with_sop && idx == 0;
      eop_i = idx == n - 1;
      sel_i = idx == 0 ? sop_sel : oth_sel;
      data_i = idx < n ? {IW'(in_im[idx]), IW'(in_re[idx])} : '0;
      #1;
      if (c >= st_lo && c <= st_hi && valid_o) chk("stall_ready", ready_o, 0);
      if (c == st_lo) held = data_o;
      if (c == st_hi && valid_o) chk("stall_hold", int'(data_o == held), 1);
      if (valid_o && ready_i && n_out < 32) begin
        o_re[n_out] = ore();
        o_im[n_out] = oim();
        o_sop[n_out] = sop_o;
        o_eop[n_out] = eop_o;
        o_sat[n_out] = sat_o;
        o_fs[n_out] = frame_sat_o;
        n_out++;
      end
      if (valid_i && ready_o) idx++;
      @(posedge clk_i); #1;
    end
    valid_i = 0; sop_i = 0; eop_i = 0; ready_i = 1;
    chk("frame_len", n_out, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    valid_i = 0; sop_i = 0; eop_i = 0; ready_i = 1; clr_i = 0; sel_i = '0; data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", int'(data_o), 0);
    chk("rst_sop_eop", int'({sop_o, eop_o}), 0);
    chk("rst_sat", int'({sat_o, frame_sat_o}), 0);
    chk("rst_cnt", sat_cnt_o, 0);
    rst_i = 0;
    @(posedge clk_i); #1;

    tv[0] = '{0, 300, -5, 127, -5, 1, 127, -5, 1};
    tv[1] = '{0, -300, 100, -128, 100, 1, -128, 100, 1};
    tv[2] = '{0, 50, -128, 50, -128, 0, 50, -128, 0};
    tv[3] = '{2, -512, 0, -128, 0, 0, -128, 0, 0};
    tv[4] = '{2, 511, -1, 127, -1, 0, 127, 0, 1};
    tv[5] = '{2, 6, -6, 1, -2, 0, 2, -1, 0};
    tv[6] = '{7, 400, -400, 100, -100, 0, 100, -100, 0};
    tv[7] = '{1, 255, -256, 127, -128, 0, 127, -128, 1};
    tv[8] = '{2, 3, 2, 0, 0, 0, 1, 1, 0};
    for (int i = 0; i < 9; i++) begin
      sel_i = SEL_W'(tv[i].sel);
      data_i = {IW'(tv[i].im), IW'(tv[i].re)};
      valid_i = 1; sop_i = 1; eop_i = 1;
      #1 chk("vec_ready", ready_o, 1);
      @(posedge clk_i); #1;
      valid_i = 0; sop_i = 0; eop_i = 0;
      chk("vec_lat1", valid_o, 0);
      @(posedge clk_i); #1;
      chk("vec_valid", valid_o, 1);
      chk("vec_re", ore(), RND ? tv[i].rre : tv[i].fre);
      chk("vec_im", oim(), RND ? tv[i].rim : tv[i].fim);
      chk("vec_sat", sat_o, RND ? tv[i].rsat : tv[i].fsat);
      chk("vec_fsat", frame_sat_o, RND ? tv[i].rsat : tv[i].fsat);
      chk("vec_sop_eop", int'({sop_o, eop_o}), 3);
      @(posedge clk_i); #1;
    end
    chk("cnt_tbl", sat_cnt_o, RND ? 4 : 2);

    for (int i = 0; i < 10; i++) begin
      in_re[i] = 4 * i - 20;
      in_im[i] = -4 * i - 1;
    end
    sop_sel = 1; oth_sel = 2;
    run_frame(10, 3, 5, 1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_re", o_re[i], 2 * i - 10);
      chk("bp_im", o_im[i], RND ? -2 * i : -2 * i - 1);
      chk("bp_sop", o_sop[i], int'(i == 0));
      chk("bp_eop", o_eop[i], int'(i == 9));
    end
    in_re[0] = 8; in_im[0] = -8; sop_sel = 2;
    run_frame(1, -1, -1, 1);
    chk("sel_next_re", o_re[0], 2);
    chk("sel_next_im", o_im[0], -2);

    in_re[0] = 0; in_re[1] = 200; in_re[2] = 0;
    in_im[0] = 0; in_im[1] = 0; in_im[2] = 0;
    sop_sel = 0; oth_sel = 0;
    run_frame(3, -1, -1, 1);
    chk("fs_b0", o_fs[0], 0);
    chk("fs_b1", o_fs[1], 0);
    chk("fs_b1_sat", o_sat[1], 1);
    chk("fs_eop", o_fs[2], 1);
    in_re[0] = 5; in_re[1] = 6;
    run_frame(2, -1, -1, 1);
    chk("fs_clean", o_fs[1], 0);

    clr_i = 1;
    @(posedge clk_i); #1;
    clr_i = 0;
    chk("cnt_clr", sat_cnt_o, 0);
    for (int i = 0; i < 20; i++) begin
      in_re[i] = 300;
      in_im[i] = -300;
    end
    run_frame(20, -1, -1, 1);
    chk("cnt_sat15", sat_cnt_o, 15);
    clr_i = 1;
    @(posedge clk_i); #1;
    clr_i = 0;
    run_frame(1, -1, -1, 1);
    chk("cnt_one", sat_cnt_o, 1);
    valid_i = 1; sop_i = 1; eop_i = 1; sel_i = 0; data_i = {IW'(0), IW'(300)};
    @(posedge clk_i); #1;
    valid_i = 0; sop_i = 0; eop_i = 0;
    for (int w = 0; w < 10 && !valid_o; w++) begin
      @(posedge clk_i); #1;
    end
    chk("clr_beat_sat", sat_o, 1);
    clr_i = 1;
    @(posedge clk_i); #1;
    clr_i = 0;
    chk("clr_wins", sat_cnt_o, 0);

    sel_i = 1; ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1; sop_i = (i == 0); eop_i = 0; data_i = {IW'(0), IW'(300)};
      @(posedge clk_i); #1;
    end
    chk("pre_rst_cnt", sat_cnt_o, 2);
    chk("pre_rst_valid", valid_o, 1);
    rst_i = 1;
    #1;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_cnt", sat_cnt_o, 0);
    chk("mid_rst_data", int'(data_o), 0);
    valid_i = 0; sop_i = 0;
    @(posedge clk_i); #1;
    rst_i = 0;
    @(posedge clk_i); #1;
    in_re[0] = 100; in_im[0] = -100; oth_sel = 3;
    run_frame(1, -1, -1, 0);
    chk("post_rst_sel0", o_re[0], 100);
    chk("post_rst_im", o_im[0], -100);
    chk("post_rst_sop", o_sop[0], 0);
    chk("post_rst_eop", o_eop[0], 1);
    chk("post_rst_fs", o_fs[0], 0);
    sop_sel = 0;
    run_frame(1, -1, -1, 1);
    chk("post_rst_1beat", o_re[0], 100);
    chk("post_rst_1beat_se", int'({o_sop[0], o_eop[0]}), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
